// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_res_e;

  localparam logic [3:0] COL_RST = 4'b1110;

  // Indexed {row, col}; element 15 (row 3, col 3) is the leftmost nibble.
  localparam logic [15:0][3:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_frame_collect.sv
// Column strobing, row synchronizer and per-frame hit classification.
module keypad_frame_collect
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       frame_done,
  output frame_res_e frame_result,
  output logic [3:0] frame_code
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0]   presc;
  logic [1:0]      col_idx;
  logic [1:0][3:0] row_sync;
  logic [1:0]      hit_cnt;
  logic [3:0]      hit_code;

  logic       tc;
  logic [3:0] row_hit;
  logic [2:0] col_hits;
  logic [1:0] col_cnt;
  logic [1:0] row_idx;
  logic [2:0] tot;
  logic [1:0] next_cnt;
  logic [3:0] next_code;

  assign tc      = (presc == PW'(SCAN_DIV - 1));
  assign row_hit = ~row_sync[1];

  // Hit count saturates at 2: anything beyond one hit is already MULTI.
  always_comb begin
    row_idx = '0;
    for (int r = 3; r >= 0; r--)
      if (row_hit[r]) row_idx = 2'(r);
    col_hits  = 3'($countones(row_hit));
    col_cnt   = (col_hits > 3'd1) ? 2'd2 : col_hits[1:0];
    tot       = {1'b0, hit_cnt} + {1'b0, col_cnt};
    next_cnt  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    next_code = (col_cnt == 2'd1) ? key_lookup(row_idx, col_idx) : hit_code;
  end

  always_comb begin
    frame_done   = tc && (col_idx == 2'd3);
    frame_code   = next_code;
    frame_result = FR_NONE;
    if (next_cnt == 2'd1)      frame_result = FR_SINGLE;
    else if (next_cnt == 2'd2) frame_result = FR_MULTI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_sync <= {4'hF, 4'hF};
      presc    <= '0;
      col_idx  <= '0;
      col_n    <= COL_RST;
      hit_cnt  <= '0;
      hit_code <= '0;
    end else begin
      row_sync <= {row_sync[0], row_n};
      if (tc) begin
        presc   <= '0;
        col_idx <= col_idx + 2'd1;
        col_n   <= {col_n[2:0], col_n[3]};
        if (col_idx == 2'd3) begin
          hit_cnt  <= '0;
          hit_code <= '0;
        end else begin
          hit_cnt  <= next_cnt;
          hit_code <= next_code;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: frame-level debounce and one key_valid pulse per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int            CW      = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

  logic       frame_done;
  frame_res_e frame_result;
  logic [3:0] frame_code;

  kp_state_e     state;
  logic [CW-1:0] cnt;
  logic [3:0]    cand;

  keypad_frame_collect #(.SCAN_DIV(SCAN_DIV)) u_collect (
    .clk          (clk),
    .rst          (rst),
    .row_n        (row_n),
    .col_n        (col_n),
    .frame_done   (frame_done),
    .frame_result (frame_result),
    .frame_code   (frame_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        unique case (state)
          ST_IDLE: begin
            if (frame_result == FR_SINGLE) begin
              cand <= frame_code;
              cnt  <= CW'(1);
              if (DEBOUNCE_FRAMES == 1) begin
                state     <= ST_PRESSED;
                key_code  <= frame_code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end else begin
                state <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (frame_result == FR_SINGLE && frame_code == cand) begin
              cnt <= cnt + 1'b1;
              if (cnt + 1'b1 == CNT_MAX) begin
                state     <= ST_PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end
            end else if (frame_result == FR_SINGLE) begin
              cand <= frame_code;
              cnt  <= CW'(1);
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
          // Any activity while held keeps the key; no rollover pulse.
          ST_PRESSED: begin
            if (frame_result == FR_NONE) begin
              if (DEBOUNCE_FRAMES == 1) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                key_down <= 1'b0;
              end else begin
                state <= ST_RELEASE;
                cnt   <= CW'(1);
              end
            end
          end
          ST_RELEASE: begin
            if (frame_result == FR_NONE) begin
              if (cnt + 1'b1 == CNT_MAX) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                key_down <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= ST_PRESSED;
              cnt   <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a frame-level behavioural model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DF = 2;
  localparam int FL = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n, col_n, key_code;
  logic       key_valid, key_down;

  logic [3:0][3:0] keys = '0;   // keys[row][col], 1 = pressed
  int unsigned kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Physical matrix: a row reads low when a pressed key joins it to the driven column.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r] & ~col_n);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: counts cycles since reset, classifies each frame from the key set, tracks press runs.
  int   cyc = 0;
  bit   armed = 0;
  bit   m_held = 0;
  int   m_run_key = 0, m_run_len = 0, m_empty = 0, m_pulses = 0;
  int   fn, fk;
  logic [3:0] m_code = '0;
  bit   m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; armed = 1; m_held = 0; m_run_len = 0; m_empty = 0;
      m_code = '0; m_valid = 0;
    end else begin
      m_valid = 0;
      cyc++;
      if (cyc % FL == 0) begin
        fn = 0; fk = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (keys[r][c]) begin fn++; fk = int'(kmap[r][c]); end
        if (!m_held) begin
          if (fn == 1) begin
            m_run_len = (m_run_len > 0 && fk == m_run_key) ? m_run_len + 1 : 1;
            m_run_key = fk;
            if (m_run_len >= DF) begin
              m_held = 1; m_code = 4'(fk); m_valid = 1; m_pulses++; m_empty = 0;
            end
          end else begin
            m_run_len = 0;
          end
        end else if (fn == 0) begin
          m_empty++;
          if (m_empty >= DF) begin m_held = 0; m_run_len = 0; m_empty = 0; end
        end else begin
          m_empty = 0;
        end
      end
    end
  end

  int   d_pulses = 0;
  logic prev_valid = 1'b0;
  logic [3:0] one = 4'b0001;
  logic [3:0] col_exp;

  always @(negedge clk) begin
    if (armed) begin
      col_exp = ~(one << ((cyc / SD) % 4));
      chk("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
      chk("key_down", {31'd0, key_down}, {31'd0, m_held});
      chk("key_code", {28'd0, key_code}, {28'd0, m_code});
      chk("col_n", {28'd0, col_n}, {28'd0, col_exp});
      chk("col_onehot", $countones(~col_n), 1);
      if (key_valid) begin
        d_pulses++;
        chk("valid_consecutive", {31'd0, prev_valid}, 32'd0);
      end
      prev_valid = key_valid;
    end
  end

  task automatic frames(input int n);
    repeat (n * FL) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_n", {28'd0, col_n}, 32'h0000000E);
    chk("rst_code", {28'd0, key_code}, 0);
    chk("rst_valid", {31'd0, key_valid}, 0);
    chk("rst_down", {31'd0, key_down}, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rot_col_n", {28'd0, col_n}, 32'h0000000D);
    repeat (12) @(posedge clk);
    #1;

    // Bounce on D
    keys[3][3] = 1'b1; frames(1);
    keys = '0;         frames(1);
    keys[3][3] = 1'b1; frames(1);
    keys = '0;         frames(2);
    chk("bounce_pulses", d_pulses, 0);
    chk("bounce_code", {28'd0, key_code}, 0);

    // Single press of 5
    keys[1][1] = 1'b1; frames(1);
    chk("p5_early", {31'd0, key_valid}, 0);
    frames(1);
    chk("p5_valid", {31'd0, key_valid}, 1);
    chk("p5_code", {28'd0, key_code}, 5);
    frames(2);
    keys = '0; frames(1);
    chk("p5_down_hold", {31'd0, key_down}, 1);
    frames(1);
    chk("p5_down_rel", {31'd0, key_down}, 0);

    // Ghost: 1 and 9 together, then 9 released
    keys[0][0] = 1'b1; keys[2][2] = 1'b1; frames(5);
    chk("ghost_down", {31'd0, key_down}, 0);
    chk("ghost_pulses", d_pulses, 1);
    keys[2][2] = 1'b0; frames(1);
    chk("ghost_early", {31'd0, key_valid}, 0);
    frames(1);
    chk("ghost_valid", {31'd0, key_valid}, 1);
    chk("ghost_code", {28'd0, key_code}, 1);
    keys = '0; frames(2);

    // Repeat press of 3
    keys[0][2] = 1'b1; frames(2);
    chk("r3a_valid", {31'd0, key_valid}, 1);
    chk("r3a_code", {28'd0, key_code}, 3);
    keys = '0; frames(2);
    chk("r3_down", {31'd0, key_down}, 0);
    keys[0][2] = 1'b1; frames(2);
    chk("r3b_valid", {31'd0, key_valid}, 1);
    keys = '0; frames(2);

    // Rollover A -> A+B -> B
    keys[0][3] = 1'b1; frames(2);
    chk("rA_code", {28'd0, key_code}, 10);
    keys[1][3] = 1'b1; frames(2);
    keys[0][3] = 1'b0; frames(2);
    chk("rB_code", {28'd0, key_code}, 10);
    chk("rB_down", {31'd0, key_down}, 1);
    chk("rB_pulses", d_pulses, 5);
    keys = '0; frames(2);

    // One-frame dropout during a hold
    keys[1][1] = 1'b1; frames(3);
    keys = '0; frames(1);
    chk("drop_down", {31'd0, key_down}, 1);
    keys[1][1] = 1'b1; frames(2);
    chk("drop_pulses", d_pulses, 6);
    keys = '0; frames(2);
    chk("drop_rel", {31'd0, key_down}, 0);

    // Reset while 7 is held
    keys[2][0] = 1'b1; frames(2);
    chk("k7_code", {28'd0, key_code}, 7);
    frames(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_code", {28'd0, key_code}, 0);
    chk("mrst_down", {31'd0, key_down}, 0);
    chk("mrst_col", {28'd0, col_n}, 32'h0000000E);
    rst = 1'b0;
    frames(2);
    chk("k7b_valid", {31'd0, key_valid}, 1);
    chk("k7b_code", {28'd0, key_code}, 7);
    keys = '0; frames(2);

    chk("dut_pulses", d_pulses, 8);
    chk("model_pulses", m_pulses, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
